id_ex_stage: RTL and testbench

ID/EX pipeline register with integrated load-use hazard detection and flush/bubble control. It captures the decoded control bundle, register operands and immediate from the decode stage, and presents them registered to the execute stage. It stalls the IF and ID stages on a load-use dependency and squashes the ID slot on an EX-stage redirect. It keeps two saturating event counters for stalls and flushes.

---
 rtl/id_ex_stage.sv | 135 +++++++++++++
 tb/tb_id_ex_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, redirect flush and saturating event counters.
// Latency: one cycle from a capturing edge to ex_*; stall_if_id is combinational.
// Backpressure: mem_stall freezes ex_* and the counters; load-use inserts a single bubble and holds IF/ID.
module id_ex_stage #(
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [DW-1:0] id_pc,
  input  logic [4:0]    id_rs1,
  input  logic [4:0]    id_rs2,
  input  logic [4:0]    id_rd,
  input  logic          id_use_rs1,
  input  logic          id_use_rs2,
  input  logic [DW-1:0] id_rd1,
  input  logic [DW-1:0] id_rd2,
  input  logic [DW-1:0] id_imm,
  input  logic          id_regwrite,
  input  logic          id_memwrite,
  input  logic          id_alusrc,
  input  logic [4:0]    id_aluop,
  input  logic [2:0]    id_npcop,
  input  logic [2:0]    id_wdsel,
  input  logic [2:0]    id_dmtype,
  input  logic          ex_redirect,
  input  logic          mem_stall,
  output logic          ex_valid,
  output logic [DW-1:0] ex_pc,
  output logic [4:0]    ex_rs1,
  output logic [4:0]    ex_rs2,
  output logic [4:0]    ex_rd,
  output logic [DW-1:0] ex_rd1,
  output logic [DW-1:0] ex_rd2,
  output logic [DW-1:0] ex_imm,
  output logic          ex_regwrite,
  output logic          ex_memwrite,
  output logic          ex_alusrc,
  output logic [4:0]    ex_aluop,
  output logic [2:0]    ex_npcop,
  output logic [2:0]    ex_wdsel,
  output logic [2:0]    ex_dmtype,
  output logic          stall_if_id,
  output logic [CW-1:0] stall_cnt,
  output logic [CW-1:0] flush_cnt
);

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] pc;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [4:0]    rd;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [DW-1:0] imm;
    logic          regwrite;
    logic          memwrite;
    logic          alusrc;
    logic [4:0]    aluop;
    logic [2:0]    npcop;
    logic [2:0]    wdsel;
    logic [2:0]    dmtype;
  } ex_bundle_t;

  ex_bundle_t    ex_q, ex_d, id_bundle;
  logic [CW-1:0] stall_cnt_q, stall_cnt_d;
  logic [CW-1:0] flush_cnt_q, flush_cnt_d;
  logic          ex_is_load;
  logic          load_use;

  assign id_bundle = {1'b1, id_pc, id_rs1, id_rs2, id_rd, id_rd1, id_rd2, id_imm,
                      id_regwrite, id_memwrite, id_alusrc, id_aluop, id_npcop,
                      id_wdsel, id_dmtype};

  // Loads are every non-ALU, non-PC write-data source; x0 destinations never create a dependency.
  assign ex_is_load  = ex_q.valid & (ex_q.wdsel != 3'b000) & (ex_q.wdsel != 3'b110);
  assign load_use    = id_valid & ex_is_load & (ex_q.rd != 5'd0) &
                       ((id_use_rs1 & (id_rs1 == ex_q.rd)) | (id_use_rs2 & (id_rs2 == ex_q.rd)));
  // A redirect squashes the dependent instruction anyway, so it cancels the load-use hold.
  assign stall_if_id = mem_stall | (load_use & ~ex_redirect);

  // Next-state selection in priority order: hold, flush, load-use bubble, idle bubble, capture.
  always_comb begin
    ex_d        = ex_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (mem_stall) begin
      ex_d = ex_q;
    end else if (ex_redirect) begin
      ex_d = '0;
      if (~&flush_cnt_q) flush_cnt_d = flush_cnt_q + CW'(1);
    end else if (load_use) begin
      ex_d = '0;
      if (~&stall_cnt_q) stall_cnt_d = stall_cnt_q + CW'(1);
    end else if (!id_valid) begin
      ex_d = '0;
    end else begin
      ex_d = id_bundle;
    end
  end

  // Pipeline register and counters, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ex_valid    = ex_q.valid;
  assign ex_pc       = ex_q.pc;
  assign ex_rs1      = ex_q.rs1;
  assign ex_rs2      = ex_q.rs2;
  assign ex_rd       = ex_q.rd;
  assign ex_rd1      = ex_q.rd1;
  assign ex_rd2      = ex_q.rd2;
  assign ex_imm      = ex_q.imm;
  assign ex_regwrite = ex_q.regwrite;
  assign ex_memwrite = ex_q.memwrite;
  assign ex_alusrc   = ex_q.alusrc;
  assign ex_aluop    = ex_q.aluop;
  assign ex_npcop    = ex_q.npcop;
  assign ex_wdsel    = ex_q.wdsel;
  assign ex_dmtype   = ex_q.dmtype;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage with a queue-based scoreboard.
// Stimulus pushes hand-derived expectations; a monitor checks stall_if_id before each edge
// and the registered bundle and counters just after it.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic        regwrite;
    logic        memwrite;
    logic        alusrc;
    logic [4:0]  aluop;
    logic [2:0]  npcop;
    logic [2:0]  wdsel;
    logic [2:0]  dmtype;
  } bun_t;

  typedef struct {
    bun_t       exp;
    logic [3:0] sc;
    logic [3:0] fc;
    logic       stall;
    logic       async_chk;
    string      name;
  } ent_t;

  localparam int CAP = 0, BUB = 1, HOLD = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bun_t id = '0;
  logic use1 = 1'b0, use2 = 1'b0, redirect = 1'b0, mstall = 1'b0;
  logic [31:0] pc_ctr = 32'h0000_1000;

  bun_t       act;
  logic       stall_if_id;
  logic [3:0] stall_cnt, flush_cnt;
  logic       ex_valid, ex_regwrite, ex_memwrite, ex_alusrc;
  logic [31:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
  logic [4:0] ex_rs1, ex_rs2, ex_rd, ex_aluop;
  logic [2:0] ex_npcop, ex_wdsel, ex_dmtype;

  ent_t q[$];
  bun_t prev_exp = '0;
  int   tests = 0, fails = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DW(32), .CW(4)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id.valid), .id_pc(id.pc), .id_rs1(id.rs1), .id_rs2(id.rs2), .id_rd(id.rd),
    .id_use_rs1(use1), .id_use_rs2(use2), .id_rd1(id.rd1), .id_rd2(id.rd2), .id_imm(id.imm),
    .id_regwrite(id.regwrite), .id_memwrite(id.memwrite), .id_alusrc(id.alusrc),
    .id_aluop(id.aluop), .id_npcop(id.npcop), .id_wdsel(id.wdsel), .id_dmtype(id.dmtype),
    .ex_redirect(redirect), .mem_stall(mstall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_regwrite(ex_regwrite),
    .ex_memwrite(ex_memwrite), .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop),
    .ex_npcop(ex_npcop), .ex_wdsel(ex_wdsel), .ex_dmtype(ex_dmtype),
    .stall_if_id(stall_if_id), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  assign act = {ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_rd1, ex_rd2, ex_imm, ex_regwrite,
                ex_memwrite, ex_alusrc, ex_aluop, ex_npcop, ex_wdsel, ex_dmtype};

  task automatic chk_out(input ent_t e);
    tests++;
    if (act !== e.exp) begin
      fails++;
      $display("FAIL %s bundle: got %h want %h", e.name, act, e.exp);
    end
    tests++;
    if (stall_cnt !== e.sc || flush_cnt !== e.fc) begin
      fails++;
      $display("FAIL %s counters: got stall=%0d flush=%0d want stall=%0d flush=%0d",
               e.name, stall_cnt, flush_cnt, e.sc, e.fc);
    end
  endtask

  task automatic chk_stall(input ent_t e);
    tests++;
    if (stall_if_id !== e.stall) begin
      fails++;
      $display("FAIL %s stall_if_id: got %b want %b", e.name, stall_if_id, e.stall);
    end
  endtask

  // Monitor: pop one expectation per cycle; stall checked before the edge, registers after it.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk_stall(e);
        if (e.async_chk) begin
          chk_out(e);
        end else begin
          @(posedge clk);
          #1;
          chk_out(e);
        end
      end
    end
  end

  // Present a valid instruction in the ID slot; other fields are varied from the PC.
  task automatic instr(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [2:0] wdsel,
                       input logic [4:0] aluop);
    id.valid    = 1'b1;
    id.pc       = pc_ctr;
    id.rs1      = rs1;
    id.rs2      = rs2;
    id.rd       = rd;
    id.rd1      = 32'hDEAD_0000 ^ pc_ctr;
    id.rd2      = 32'h0BEE_F000 + pc_ctr;
    id.imm      = pc_ctr ^ 32'h5A5A_5A5A;
    id.regwrite = (rd != 5'd0);
    id.memwrite = 1'b0;
    id.alusrc   = (wdsel != 3'b000);
    id.aluop    = aluop;
    id.npcop    = (wdsel == 3'b110) ? 3'b010 : 3'b000;
    id.wdsel    = wdsel;
    id.dmtype   = wdsel;
    use1        = u1;
    use2        = u2;
    pc_ctr      = pc_ctr + 32'd4;
  endtask

  // Called at posedge+2 with inputs set; pushes the expectation and advances one cycle.
  task automatic step(input int kind, input logic [3:0] sc, input logic [3:0] fc,
                      input logic stall, input string name);
    ent_t e;
    case (kind)
      CAP:     e.exp = id;
      BUB:     e.exp = '0;
      default: e.exp = prev_exp;
    endcase
    prev_exp    = e.exp;
    e.sc        = sc;
    e.fc        = fc;
    e.stall     = stall;
    e.async_chk = 1'b0;
    e.name      = name;
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic async_reset_check(input string name);
    ent_t e;
    e.exp       = '0;
    e.sc        = 4'd0;
    e.fc        = 4'd0;
    e.stall     = 1'b0;
    e.async_chk = 1'b1;
    e.name      = name;
    prev_exp    = '0;
    q.push_back(e);
  endtask

  initial begin
    logic [3:0] sc_exp;
    #1 async_reset_check("reset_init");
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;

    instr(5'd3, 5'd1, 5'd2, 1, 1, 3'b000, 5'd1);  step(CAP, 0, 0, 0, "cap_add");
    instr(5'd4, 5'd3, 5'd3, 1, 1, 3'b000, 5'd2);  step(CAP, 0, 0, 0, "cap_sub");
    // lw x5 then add x6,x5,x1: one bubble, then capture
    instr(5'd5, 5'd2, 5'd0, 1, 0, 3'b001, 5'd1);  step(CAP, 0, 0, 0, "cap_lw");
    instr(5'd6, 5'd5, 5'd1, 1, 1, 3'b000, 5'd1);  step(BUB, 1, 0, 1, "lu_stall");
    pc_ctr = pc_ctr - 32'd4;
    instr(5'd6, 5'd5, 5'd1, 1, 1, 3'b000, 5'd1);  step(CAP, 1, 0, 0, "lu_resume");
    // lw x0 then use of x0
    instr(5'd0, 5'd1, 5'd0, 1, 0, 3'b001, 5'd1);  step(CAP, 1, 0, 0, "cap_lw_x0");
    instr(5'd7, 5'd0, 5'd0, 1, 1, 3'b000, 5'd1);  step(CAP, 1, 0, 0, "nostall_x0");
    // jal x5 then use of x5
    instr(5'd5, 5'd0, 5'd0, 0, 0, 3'b110, 5'd0);  step(CAP, 1, 0, 0, "cap_jal");
    instr(5'd8, 5'd5, 5'd0, 1, 0, 3'b000, 5'd1);  step(CAP, 1, 0, 0, "nostall_jal");
    // lw x5 then rs2=5 without use_rs2
    instr(5'd5, 5'd2, 5'd0, 1, 0, 3'b011, 5'd1);  step(CAP, 1, 0, 0, "cap_lw2");
    instr(5'd9, 5'd1, 5'd5, 1, 0, 3'b000, 5'd1);  step(CAP, 1, 0, 0, "nostall_unused_rs2");
    // redirect together with load-use
    instr(5'd5, 5'd2, 5'd0, 1, 0, 3'b001, 5'd1);  step(CAP, 1, 0, 0, "cap_lw3");
    instr(5'd10, 5'd5, 5'd0, 1, 0, 3'b000, 5'd1);
    redirect = 1'b1;                              step(BUB, 1, 1, 0, "redir_lu");
    redirect = 1'b0;
    id.valid = 1'b0;                              step(BUB, 1, 1, 0, "idle");
    // mem_stall for three cycles with changing ID and redirect
    instr(5'd11, 5'd1, 5'd2, 1, 1, 3'b000, 5'd3); step(CAP, 1, 1, 0, "pre_hold");
    mstall = 1'b1;
    redirect = 1'b1;
    for (int i = 0; i < 3; i++) begin
      instr(5'(12 + i), 5'd11, 5'd1, 1, 1, 3'b000, 5'd4);
      step(HOLD, 1, 1, 1, "hold");
    end
    mstall = 1'b0;
    redirect = 1'b0;
    instr(5'd15, 5'd1, 5'd1, 1, 1, 3'b000, 5'd5); step(CAP, 1, 1, 0, "hold_resume");
    // mem_stall while a load-use is pending: held, no count, then the bubble
    instr(5'd5, 5'd2, 5'd0, 1, 0, 3'b010, 5'd1);  step(CAP, 1, 1, 0, "cap_lw4");
    instr(5'd16, 5'd0, 5'd5, 0, 1, 3'b000, 5'd1);
    mstall = 1'b1;                                step(HOLD, 1, 1, 1, "hold_lu");
    mstall = 1'b0;                                step(BUB, 2, 1, 1, "lu_after_hold");
    step(CAP, 2, 1, 0, "lu_after_hold_cap");
    // saturation: 20 load-use events, stalled load re-presented
    sc_exp = 4'd2;
    for (int i = 0; i < 20; i++) begin
      instr(5'd5, 5'd2, 5'd0, 1, 0, 3'b001, 5'd1); step(CAP, sc_exp, 1, 0, "sat_lw");
      sc_exp = (sc_exp == 4'd15) ? 4'd15 : sc_exp + 4'd1;
      instr(5'd6, 5'd5, 5'd0, 1, 0, 3'b000, 5'd1); step(BUB, sc_exp, 1, 1, "sat_stall");
    end
    instr(5'd7, 5'd1, 5'd2, 1, 1, 3'b000, 5'd1);  step(CAP, 15, 1, 0, "sat_final");
    // asynchronous reset between edges
    rst = 1'b1;
    async_reset_check("reset_mid");
    @(posedge clk);
    #2 rst = 1'b0;
    instr(5'd8, 5'd1, 5'd2, 1, 1, 3'b000, 5'd6);  step(CAP, 0, 0, 0, "post_reset_cap");
    id.valid = 1'b0;                              step(BUB, 0, 0, 0, "post_reset_idle");

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, tests=%0d", tests);
    $fatal(1, "timeout");
  end

endmodule
